// File: rtl/fsm_prog_pkg.sv
// fsm_prog_pkg: shared types, constants and state-encoding helpers for the programmable FSM.
package fsm_prog_pkg;
    localparam int DEF_NSTATE    = 6;
    localparam int DEF_IN_W      = 2;
    localparam int DEF_OUT_W     = 1;
    localparam int DEF_SW        = $clog2(DEF_NSTATE);
    localparam int ILLEGAL_CNT_W = 8;

    typedef enum logic {MODE_RUN = 1'b0, MODE_TRAP = 1'b1} fsm_mode_t;

    typedef struct packed {
        logic                 legal;
        logic [DEF_SW-1:0]    next;
        logic [DEF_OUT_W-1:0] out;
    } fsm_entry_t;

    function automatic logic [31:0] idx2onehot(input int unsigned idx);
        return 32'd1 << idx;
    endfunction

    function automatic int unsigned onehot2idx(input logic [31:0] oh);
        int unsigned idx = 0;
        for (int i = 0; i < 32; i++) if (oh[i]) idx = i;
        return idx;
    endfunction
endpackage

// File: rtl/fsm_prog_table.sv
// fsm_prog_table: NSTATE x 2^IN_W transition table; synchronous write, combinational read.
module fsm_prog_table
    import fsm_prog_pkg::*;
#(
    parameter int  NSTATE  = DEF_NSTATE,
    parameter int  IN_W    = DEF_IN_W,
    parameter type entry_t = fsm_entry_t,
    localparam int AW      = $clog2(NSTATE) + IN_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  entry_t        i_wdata,
    input  logic [AW-1:0] i_raddr,
    output entry_t        o_rdata
);
    localparam int DEPTH = NSTATE << IN_W;

    entry_t r_mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fsm_prog.sv
// fsm_prog: run-time programmable Mealy FSM with illegal-symbol counting.
// Optional trap on illegal symbols is enabled by defining FSM_PROG_TRAP_EN.
module fsm_prog
    import fsm_prog_pkg::*;
#(
    parameter int  NSTATE = DEF_NSTATE,
    parameter int  IN_W   = DEF_IN_W,
    parameter int  OUT_W  = DEF_OUT_W,
    localparam int SW     = $clog2(NSTATE)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [IN_W-1:0]          in_data,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic [NSTATE-1:0]        state_onehot,
    output logic                     err,
    input  logic                     err_clr,
    output logic [ILLEGAL_CNT_W-1:0] illegal_cnt,
    input  logic                     cfg_we,
    input  logic [SW-1:0]            cfg_state,
    input  logic [IN_W-1:0]          cfg_in,
    input  logic                     cfg_legal,
    input  logic [SW-1:0]            cfg_next,
    input  logic [OUT_W-1:0]         cfg_out
);
    typedef struct packed {
        logic             legal;
        logic [SW-1:0]    next;
        logic [OUT_W-1:0] out;
    } entry_t;

    fsm_mode_t                r_mode, w_mode_nxt;
    logic [SW-1:0]            r_state, w_state_nxt;
    logic                     r_out_valid, w_out_valid_nxt;
    logic [OUT_W-1:0]         r_out_data, w_out_data_nxt;
    logic [ILLEGAL_CNT_W-1:0] r_cnt, w_cnt_nxt;
    entry_t                   w_rd, w_wr;
    logic                     w_we;

    // Rows beyond NSTATE do not exist; targets beyond NSTATE become undefined transitions.
    assign w_we = cfg_we && (32'(cfg_state) < NSTATE);
    assign w_wr = '{legal: cfg_legal && (32'(cfg_next) < NSTATE), next: cfg_next, out: cfg_out};

    fsm_prog_table #(
        .NSTATE  (NSTATE),
        .IN_W    (IN_W),
        .entry_t (entry_t)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_waddr ({cfg_state, cfg_in}),
        .i_wdata (w_wr),
        .i_raddr ({r_state, in_data}),
        .o_rdata (w_rd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode      <= MODE_RUN;
            r_state     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_cnt       <= '0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_state     <= w_state_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_mode_nxt      = r_mode;
        w_state_nxt     = r_state;
        w_out_valid_nxt = 1'b0;
        w_out_data_nxt  = r_out_data;
        w_cnt_nxt       = r_cnt;
        if (r_mode == MODE_TRAP) begin
`ifdef FSM_PROG_TRAP_EN
            if (err_clr) begin
                w_mode_nxt  = MODE_RUN;
                w_state_nxt = '0;
            end
`endif
        end else if (in_valid) begin
            if (w_rd.legal) begin
                w_state_nxt     = w_rd.next;
                w_out_valid_nxt = 1'b1;
                w_out_data_nxt  = w_rd.out;
            end else begin
                w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + ILLEGAL_CNT_W'(1);
`ifdef FSM_PROG_TRAP_EN
                w_mode_nxt = MODE_TRAP;
`endif
            end
        end
    end

`ifdef FSM_PROG_TRAP_EN
    assign err = (r_mode == MODE_TRAP);
`else
    logic w_unused;
    assign w_unused = err_clr;
    assign err      = 1'b0;
`endif

    assign state_onehot = (r_mode == MODE_TRAP) ? '0 : NSTATE'(idx2onehot(32'(r_state)));
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign illegal_cnt  = r_cnt;
endmodule

// File: tb/tb_fsm_prog.sv
// tb_fsm_prog: directed and randomized checks of fsm_prog against a table-level behavioural model.
`timescale 1ns/1ps
module tb_fsm_prog;
    localparam int NS = 6;

    logic       clk = 1'b0, reset = 1'b1, in_valid = 1'b0, err_clr = 1'b0, cfg_we = 1'b0, cfg_legal = 1'b0;
    logic [1:0] in_data = '0, cfg_in = '0;
    logic [2:0] cfg_state = '0, cfg_next = '0;
    logic [0:0] cfg_out = '0;
    logic       out_valid, err;
    logic [0:0] out_data;
    logic [5:0] state_onehot;
    logic [7:0] illegal_cnt;

    always #5 clk = ~clk;

    fsm_prog #(.NSTATE(NS), .IN_W(2), .OUT_W(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .state_onehot (state_onehot),
        .err          (err),
        .err_clr      (err_clr),
        .illegal_cnt  (illegal_cnt),
        .cfg_we       (cfg_we),
        .cfg_state    (cfg_state),
        .cfg_in       (cfg_in),
        .cfg_legal    (cfg_legal),
        .cfg_next     (cfg_next),
        .cfg_out      (cfg_out)
    );

    int n_pass = 0, n_chk = 0, n_fail = 0;

    // Model: state number (-1 = trapped), table as plain arrays, counters as integers.
    bit m_legal [8][4];
    int m_next  [8][4];
    int m_out   [8][4];
    int m_state, m_cnt, m_od;
    bit m_ov;

    int ref_tab [12][4] = '{
        '{0,3,1,0}, '{0,0,5,1}, '{1,2,4,1}, '{1,1,3,0}, '{2,0,1,1}, '{2,2,5,0},
        '{3,0,2,0}, '{3,2,4,1}, '{4,1,5,1}, '{4,2,3,0}, '{5,0,5,0}, '{5,2,0,1}};
    int walk_in [6] = '{3, 2, 2, 0, 0, 2};
    int walk_oh [6] = '{2, 16, 8, 4, 2, 16};
    int walk_od [6] = '{0, 1, 0, 0, 1, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".oh"},  32'(state_onehot), (m_state < 0) ? 32'd0 : (32'd1 << m_state));
        chk({tag, ".ov"},  32'(out_valid),    32'(m_ov));
        chk({tag, ".od"},  32'(out_data),     32'(m_od));
        chk({tag, ".err"}, 32'(err),          32'(m_state < 0));
        chk({tag, ".cnt"}, 32'(illegal_cnt),  32'(m_cnt));
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_od = 0; m_ov = 0;
        for (int s = 0; s < 8; s++)
            for (int d = 0; d < 4; d++) begin
                m_legal[s][d] = 0; m_next[s][d] = 0; m_out[s][d] = 0;
            end
    endtask

    task automatic step(input string tag, input bit v, input int d, input bit clr, input bit we,
                        input int cs, input int ci, input bit cl, input int cn, input int co);
        in_valid = v; in_data = 2'(d); err_clr = clr; cfg_we = we;
        cfg_state = 3'(cs); cfg_in = 2'(ci); cfg_legal = cl; cfg_next = 3'(cn); cfg_out = 1'(co);
        @(posedge clk);
        m_ov = 0;
        if (m_state < 0) begin
            if (clr) m_state = 0;
        end else if (v) begin
            if (m_legal[m_state][d]) begin
                m_od = m_out[m_state][d];
                m_state = m_next[m_state][d];
                m_ov = 1;
            end else begin
                if (m_cnt < 255) m_cnt++;
`ifdef FSM_PROG_TRAP_EN
                m_state = -1;
`endif
            end
        end
        if (we && cs < NS) begin
            m_legal[cs][ci] = cl && (cn < NS);
            m_next[cs][ci]  = cn;
            m_out[cs][ci]   = co;
        end
        #1;
        check_all(tag);
    endtask

    task automatic feed(input string tag, input int d);
        step(tag, 1, d, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic clear_trap(input string tag);
        step(tag, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int cs, input int ci, input int cn, input int co);
        step("cfg", 0, 0, 0, 1, cs, ci, 1, cn, co);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #2;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b1;

        for (int i = 0; i < 12; i++) wr(ref_tab[i][0], ref_tab[i][1], ref_tab[i][2], ref_tab[i][3]);

        for (int i = 0; i < 6; i++) begin
            feed("walk", walk_in[i]);
            chk("walk.oh_const", 32'(state_onehot), 32'(walk_oh[i]));
            chk("walk.od_const", 32'(out_data), 32'(walk_od[i]));
            chk("walk.ov_const", 32'(out_valid), 32'd1);
        end
        feed("to_s5", 1);
        feed("to_s0", 2);

`ifdef FSM_PROG_TRAP_EN
        feed("trap", 1);
        chk("trap.oh_const", 32'(state_onehot), 32'd0);
        chk("trap.err_const", 32'(err), 32'd1);
        feed("trap_ign", 3);
        feed("trap_ign", 0);
        chk("trap.cnt_const", 32'(illegal_cnt), 32'd1);
        clear_trap("trap_clr");
        chk("trap_clr.oh_const", 32'(state_onehot), 32'd1);
        chk("trap_clr.err_const", 32'(err), 32'd0);
`else
        repeat (3) feed("hold", 1);
        chk("hold.oh_const", 32'(state_onehot), 32'd1);
        chk("hold.cnt_const", 32'(illegal_cnt), 32'd3);
`endif

        step("coll", 1, 3, 0, 1, 0, 3, 1, 2, 1);
        chk("coll.oh_const", 32'(state_onehot), 32'd2);
        chk("coll.od_const", 32'(out_data), 32'd0);
        feed("ret", 2);
        feed("ret", 1);
        feed("ret", 2);
        feed("coll_new", 3);
        chk("coll_new.oh_const", 32'(state_onehot), 32'd4);
        chk("coll_new.od_const", 32'(out_data), 32'd1);

        for (int i = 0; i < 300; i++) begin
            feed("sat", 1);
`ifdef FSM_PROG_TRAP_EN
            clear_trap("sat_clr");
`endif
        end
        chk("sat.cnt_const", 32'(illegal_cnt), 32'd255);
        feed("sat_more", 1);
        do_reset("midrst");
        chk("midrst.oh_const", 32'(state_onehot), 32'd1);
        chk("midrst.cnt_const", 32'(illegal_cnt), 32'd0);
        feed("cleared", 3);
        chk("cleared.cnt_const", 32'(illegal_cnt), 32'd1);
        chk("cleared.ov_const", 32'(out_valid), 32'd0);
`ifdef FSM_PROG_TRAP_EN
        clear_trap("cleared_clr");
`endif

        wr(6, 0, 1, 1);
        wr(0, 3, 0, 1);
        feed("guard_ok", 3);
        chk("guard_ok.ov_const", 32'(out_valid), 32'd1);
        step("guard_bad", 0, 0, 0, 1, 0, 3, 1, 7, 1);
        feed("guard_ill", 3);
        chk("guard_ill.ov_const", 32'(out_valid), 32'd0);
        chk("guard_ill.cnt_const", 32'(illegal_cnt), 32'd2);
`ifdef FSM_PROG_TRAP_EN
        clear_trap("guard_clr");
`endif

        for (int i = 0; i < 12; i++) wr(ref_tab[i][0], ref_tab[i][1], ref_tab[i][2], ref_tab[i][3]);
        for (int i = 0; i < 600; i++)
            step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 7), $urandom_range(0, 3),
                 $urandom_range(0, 5) != 0, $urandom_range(0, 7), $urandom_range(0, 1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
